change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 228 ++++++++++++++++++++++
 tb/tb_change_dispenser.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//   Vending-machine output sequencer. A request {vend_i, change_i} drops one
//   soda (fixed-length solenoid pulse) and then pays out the change owed,
//   greedily in dimes and nickels. The coin hopper acknowledges each coin.
//   Every drop is followed by a one-cycle GAP. A single pending slot buffers
//   one request that arrives while busy. A hopper that never acknowledges
//   drives the block into a FAULT state that only reset can clear.
//
// Parameters
//   PULSE_LEN    cycles soda_drop_o is held high per vend (1..15)
//   ACK_TIMEOUT  max cycles to wait for hopper_ack_i per coin (2..255)
//
// Ports
//   clk_i          in   clock, rising edge
//   rst_i          in   asynchronous active-high reset
//   vend_i         in   one-cycle soda request
//   change_i[2:0]  in   change owed in 5-cent units (0..4 legal)
//   hopper_ack_i   in   hopper confirms the requested coin was released
//   soda_drop_o    out  soda solenoid drive
//   nickel_drop_o  out  nickel hopper request
//   dime_drop_o    out  dime hopper request
//   busy_o         out  FSM not in IDLE
//   overrun_o      out  one-cycle pulse: request discarded (slot full)
//   err_o          out  one-cycle pulse: illegal change code on a started request
//   fault_o        out  sticky hopper-timeout flag
// -----------------------------------------------------------------------------
module change_dispenser #(
    parameter int PULSE_LEN   = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       vend_i,
    input  logic [2:0] change_i,
    input  logic       hopper_ack_i,
    output logic       soda_drop_o,
    output logic       nickel_drop_o,
    output logic       dime_drop_o,
    output logic       busy_o,
    output logic       overrun_o,
    output logic       err_o,
    output logic       fault_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SODA   = 3'd1,
        S_DIME   = 3'd2,
        S_NICKEL = 3'd3,
        S_GAP    = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(ACK_TIMEOUT - 1);

    // Registered state
    state_t     r_state;
    logic [2:0] r_rem;
    logic [7:0] r_wait;
    logic [3:0] r_pulse;
    logic       r_pend_valid;
    logic       r_pend_vend;
    logic [2:0] r_pend_chg;
    logic       r_overrun;
    logic       r_err;

    // Next-state / decode
    state_t     w_state_next;
    logic [2:0] w_rem_next;
    logic [7:0] w_wait_next;
    logic [3:0] w_pulse_next;
    logic       w_pend_valid_next;
    logic       w_pend_vend_next;
    logic [2:0] w_pend_chg_next;
    logic       w_overrun_next;
    logic       w_err_next;
    logic       w_req;
    logic       w_start;
    logic       w_start_vend;
    logic [2:0] w_start_chg;
    logic [2:0] w_eff_chg;
    logic       w_queue;

    assign w_req = vend_i | (change_i != 3'd0);

    always_comb begin
        w_state_next      = r_state;
        w_rem_next        = r_rem;
        w_wait_next       = r_wait;
        w_pulse_next      = r_pulse;
        w_pend_valid_next = r_pend_valid;
        w_pend_vend_next  = r_pend_vend;
        w_pend_chg_next   = r_pend_chg;
        w_overrun_next    = 1'b0;
        w_err_next        = 1'b0;
        w_start           = 1'b0;
        w_start_vend      = vend_i;
        w_start_chg       = change_i;
        w_eff_chg         = 3'd0;
        w_queue           = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_start = 1'b1;
                end
            end

            S_SODA: begin
                w_queue = 1'b1;
                if (r_pulse == PULSE_LAST) begin
                    w_pulse_next = 4'd0;
                    w_state_next = S_GAP;
                end else begin
                    w_pulse_next = r_pulse + 4'd1;
                end
            end

            S_DIME, S_NICKEL: begin
                w_queue = 1'b1;
                // An ack on the final wait cycle still counts as delivered.
                if (hopper_ack_i) begin
                    w_rem_next   = r_rem - ((r_state == S_DIME) ? 3'd2 : 3'd1);
                    w_wait_next  = 8'd0;
                    w_state_next = S_GAP;
                end else if (r_wait == WAIT_LAST) begin
                    w_wait_next  = 8'd0;
                    w_state_next = S_FAULT;
                end else begin
                    w_wait_next = r_wait + 8'd1;
                end
            end

            S_GAP: begin
                if (r_rem != 3'd0) begin
                    w_queue      = 1'b1;
                    w_state_next = (r_rem >= 3'd2) ? S_DIME : S_NICKEL;
                end else if (r_pend_valid) begin
                    // Slot drains this cycle, so a new arrival refills it
                    // instead of overrunning.
                    w_start           = 1'b1;
                    w_start_vend      = r_pend_vend;
                    w_start_chg       = r_pend_chg;
                    w_pend_valid_next = w_req;
                    w_pend_vend_next  = vend_i;
                    w_pend_chg_next   = change_i;
                end else if (w_req) begin
                    // Returning to IDLE this cycle: treat as an IDLE acceptance.
                    w_start = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end

            S_FAULT: begin
                w_pend_valid_next = 1'b0;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_queue && w_req) begin
            if (!r_pend_valid) begin
                w_pend_valid_next = 1'b1;
                w_pend_vend_next  = vend_i;
                w_pend_chg_next   = change_i;
            end else begin
                w_overrun_next = 1'b1;
            end
        end

        if (w_start) begin
            // Codes 5..7 are illegal: flag them and dispense no change.
            w_err_next   = (w_start_chg > 3'd4);
            w_eff_chg    = w_err_next ? 3'd0 : w_start_chg;
            w_rem_next   = w_eff_chg;
            w_pulse_next = 4'd0;
            w_wait_next  = 8'd0;
            if (w_start_vend) begin
                w_state_next = S_SODA;
            end else if (w_eff_chg >= 3'd2) begin
                w_state_next = S_DIME;
            end else if (w_eff_chg == 3'd1) begin
                w_state_next = S_NICKEL;
            end else begin
                w_state_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_rem        <= 3'd0;
            r_wait       <= 8'd0;
            r_pulse      <= 4'd0;
            r_pend_valid <= 1'b0;
            r_pend_vend  <= 1'b0;
            r_pend_chg   <= 3'd0;
            r_overrun    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_rem        <= w_rem_next;
            r_wait       <= w_wait_next;
            r_pulse      <= w_pulse_next;
            r_pend_valid <= w_pend_valid_next;
            r_pend_vend  <= w_pend_vend_next;
            r_pend_chg   <= w_pend_chg_next;
            r_overrun    <= w_overrun_next;
            r_err        <= w_err_next;
        end
    end

    // Outputs decoded purely from registered state.
    assign soda_drop_o   = (r_state == S_SODA);
    assign nickel_drop_o = (r_state == S_NICKEL);
    assign dime_drop_o   = (r_state == S_DIME);
    assign busy_o        = (r_state != S_IDLE);
    assign fault_o       = (r_state == S_FAULT);
    assign overrun_o     = r_overrun;
    assign err_o         = r_err;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
//   Directed, cycle-by-cycle bench for change_dispenser with default
//   parameters (PULSE_LEN=4, ACK_TIMEOUT=64). Each cycle the observed output
//   vector {soda, nickel, dime, busy, overrun, err, fault} is compared to a
//   hand-written expectation, then inputs for the next edge are driven.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       vend_i = 1'b0;
    logic [2:0] change_i = 3'd0;
    logic       hopper_ack_i = 1'b0;
    logic       soda_drop_o;
    logic       nickel_drop_o;
    logic       dime_drop_o;
    logic       busy_o;
    logic       overrun_o;
    logic       err_o;
    logic       fault_o;

    int n_tests = 0;
    int n_fail  = 0;

    // {soda, nickel, dime, busy, overrun, err, fault}
    localparam logic [6:0] IDLE_V = 7'b0000000;
    localparam logic [6:0] SODA_V = 7'b1001000;
    localparam logic [6:0] GAP_V  = 7'b0001000;
    localparam logic [6:0] DIME_V = 7'b0011000;
    localparam logic [6:0] NICK_V = 7'b0101000;
    localparam logic [6:0] FLT_V  = 7'b0001001;
    localparam logic [6:0] OVR_B  = 7'b0000100;
    localparam logic [6:0] ERR_B  = 7'b0000010;

    change_dispenser #(.PULSE_LEN(4), .ACK_TIMEOUT(64)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .vend_i       (vend_i),
        .change_i     (change_i),
        .hopper_ack_i (hopper_ack_i),
        .soda_drop_o  (soda_drop_o),
        .nickel_drop_o(nickel_drop_o),
        .dime_drop_o  (dime_drop_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o),
        .err_o        (err_o),
        .fault_o      (fault_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [6:0] outs();
        return {soda_drop_o, nickel_drop_o, dime_drop_o, busy_o,
                overrun_o, err_o, fault_o};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b expected %b", tag, got[6:0], exp[6:0]);
        end else begin
            $display("[TB] ok   %s: %b", tag, got[6:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Check the current cycle's outputs, then drive inputs for the next edge.
    task automatic cyc(input string tag, input logic [6:0] exp, input logic ack,
                       input logic vend, input logic [2:0] chg);
        check_eq(tag, {25'd0, outs()}, {25'd0, exp});
        hopper_ack_i = ack;
        vend_i       = vend;
        change_i     = chg;
        tick();
    endtask

    initial begin
        // Reset state (asynchronous, before any clock edge).
        #2 rst_i = 1'b1;
        #2 check_eq("reset outputs", {25'd0, outs()}, {25'd0, IDLE_V});
        tick();
        tick();
        rst_i = 1'b0;

        // vend + 3 units: soda x4, GAP, dime, GAP, nickel, GAP, IDLE.
        cyc("t1 idle req",  IDLE_V, 0, 1, 3);
        cyc("t1 soda1",     SODA_V, 0, 0, 0);
        cyc("t1 soda2",     SODA_V, 0, 0, 0);
        cyc("t1 soda3",     SODA_V, 0, 0, 0);
        cyc("t1 soda4",     SODA_V, 0, 0, 0);
        cyc("t1 gap1",      GAP_V,  0, 0, 0);
        cyc("t1 dime w0",   DIME_V, 0, 0, 0);
        cyc("t1 dime ack",  DIME_V, 1, 0, 0);
        cyc("t1 gap2",      GAP_V,  0, 0, 0);
        cyc("t1 nick w0",   NICK_V, 0, 0, 0);
        cyc("t1 nick ack",  NICK_V, 1, 0, 0);
        cyc("t1 gap3",      GAP_V,  0, 0, 0);

        // 4 units, no vend: two dimes split by one GAP; ack in GAP ignored.
        cyc("t2 idle req",  IDLE_V, 0, 0, 4);
        cyc("t2 dime1 w0",  DIME_V, 0, 0, 0);
        cyc("t2 dime1 ack", DIME_V, 1, 0, 0);
        cyc("t2 gap ackhi", GAP_V,  1, 0, 0);
        cyc("t2 dime2 ack", DIME_V, 1, 0, 0);
        cyc("t2 gap2",      GAP_V,  0, 0, 0);

        // Pending request queued, third request overruns.
        cyc("t3 idle req",  IDLE_V, 0, 1, 0);
        cyc("t3 soda1 q",   SODA_V, 0, 0, 1);
        cyc("t3 soda2 ovr", SODA_V, 0, 1, 2);
        cyc("t3 soda3 ovrp", SODA_V | OVR_B, 0, 0, 0);
        cyc("t3 soda4",     SODA_V, 0, 0, 0);
        cyc("t3 gap pend",  GAP_V,  0, 0, 0);
        cyc("t3 nick w0",   NICK_V, 0, 0, 0);
        cyc("t3 nick ack",  NICK_V, 1, 0, 0);
        cyc("t3 gap2",      GAP_V,  0, 0, 0);

        // Illegal change code 6: err pulse, soda only.
        cyc("t4 idle req",  IDLE_V, 0, 1, 6);
        cyc("t4 soda1 err", SODA_V | ERR_B, 0, 0, 0);
        cyc("t4 soda2",     SODA_V, 0, 0, 0);
        cyc("t4 soda3",     SODA_V, 0, 0, 0);
        cyc("t4 soda4",     SODA_V, 0, 0, 0);
        cyc("t4 gap",       GAP_V,  0, 0, 0);

        // Request in the GAP that returns to IDLE starts directly.
        cyc("t5 idle req",  IDLE_V, 0, 0, 1);
        cyc("t5 nick ack",  NICK_V, 1, 0, 0);
        cyc("t5 gap req",   GAP_V,  0, 0, 2);
        cyc("t5 dime ack",  DIME_V, 1, 0, 0);
        cyc("t5 gap",       GAP_V,  0, 0, 0);

        // Asynchronous reset while nickel_drop_o is high.
        cyc("t6 idle req",  IDLE_V, 0, 0, 1);
        cyc("t6 nick w0",   NICK_V, 0, 0, 0);
        #2 rst_i = 1'b1;
        #1 check_eq("t6 async rst", {25'd0, outs()}, {25'd0, IDLE_V});
        tick();
        tick();
        rst_i = 1'b0;
        cyc("t6 post rst req", IDLE_V, 0, 0, 2);
        cyc("t6 dime ack",  DIME_V, 1, 0, 0);
        cyc("t6 gap",       GAP_V,  0, 0, 0);

        // Hopper timeout: dime held for 64 wait cycles, then FAULT.
        cyc("t7 idle req",  IDLE_V, 0, 0, 2);
        for (int i = 0; i < 64; i++) begin
            cyc("t7 dime wait", DIME_V, 0, 0, 0);
        end
        cyc("t7 fault req",   FLT_V, 1, 0, 4);
        cyc("t7 fault req2",  FLT_V, 0, 1, 1);
        cyc("t7 fault hold",  FLT_V, 0, 0, 0);
        rst_i = 1'b1;
        #1 check_eq("t7 rst clears", {25'd0, outs()}, {25'd0, IDLE_V});
        tick();
        rst_i = 1'b0;
        cyc("t7 post rst req", IDLE_V, 0, 1, 0);
        cyc("t7 soda1",     SODA_V, 0, 0, 0);
        cyc("t7 soda2",     SODA_V, 0, 0, 0);
        cyc("t7 soda3",     SODA_V, 0, 0, 0);
        cyc("t7 soda4",     SODA_V, 0, 0, 0);
        cyc("t7 gap",       GAP_V,  0, 0, 0);
        cyc("t7 idle end",  IDLE_V, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
